// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer slice.
package countdown_pkg;

    localparam int COUNTDOWN_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/down_counter_core.sv
// WIDTH-bit down-counter register with sync clear, flush, load and a
// decrement that floors at zero; exposes a zero flag.
module down_counter_core
    import countdown_pkg::*;
#(
    parameter int WIDTH = COUNTDOWN_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!clr || flush) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter timer with valid/ready load, pause, abort and a
// registered terminal-count pulse. Define COUNTDOWN_AUTO_RELOAD_EN for periodic mode.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = COUNTDOWN_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             expired
);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic             zero;
    logic             running;
    logic             accept;
    logic             terminal;
    logic             core_load;
    logic [WIDTH-1:0] core_val;

    assign running  = (state == RUN);
    assign accept   = load_valid && load_ready;
    // abort beats a coincident terminal, so it is masked out here
    assign terminal = running && en && zero && !abort;

    assign core_load = accept || (AUTO_RELOAD && terminal);
    assign core_val  = accept ? load_val : reload;

    down_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .clr      (clr),
        .flush    (running && abort),
        .load     (core_load),
        .load_val (core_val),
        .dec      (running && en && !abort),
        .count    (count),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            state  <= IDLE;
            tc     <= 1'b0;
            reload <= '0;
        end else begin
            tc <= terminal;
            case (state)
                IDLE, DONE: begin
                    if (load_valid) begin
                        state  <= RUN;
                        reload <= load_val;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (terminal && !AUTO_RELOAD) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state == RUN);
    assign load_ready = (state == IDLE) || (state == DONE);
    assign expired    = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// traffic, compared against a rule-level behavioural model.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk;
    logic       clr;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_val;
    logic       en;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       expired;

    int checks   = 0;
    int failures = 0;

    // Model: mode 0=idle, 1=running, 2=finished
    int m_mode    = 0;
    int m_count   = 0;
    int m_reload  = 0;
    bit m_tc      = 0;
    bit m_expired = 0;

    countdown_timer #(.WIDTH(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_val   (load_val),
        .en         (en),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .tc         (tc),
        .expired    (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check_output({where, ".count"},      32'(count),      32'(m_count));
        check_output({where, ".tc"},         32'(tc),         32'(m_tc));
        check_output({where, ".busy"},       32'(busy),       32'(m_mode == 1));
        check_output({where, ".expired"},    32'(expired),    32'(m_expired));
        check_output({where, ".load_ready"}, 32'(load_ready), 32'(m_mode != 1));
    endtask

    task automatic model_edge(input bit c, input bit lv, input int lval, input bit e, input bit ab);
        if (!c) begin
            m_mode = 0; m_count = 0; m_tc = 0; m_expired = 0;
        end else begin
            m_tc = 0;
            if (m_mode != 1) begin
                if (lv) begin
                    m_mode = 1; m_count = lval; m_reload = lval; m_expired = 0;
                end
            end else if (ab) begin
                m_mode = 0; m_count = 0;
            end else if (e) begin
                if (m_count == 0) begin
                    m_tc = 1;
                    if (AUTO) m_count = m_reload;
                    else begin
                        m_mode = 2; m_expired = 1;
                    end
                end else begin
                    m_count = m_count - 1;
                end
            end
        end
    endtask

    task automatic apply_stimulus(input bit c, input bit lv, input int lval, input bit e,
                                  input bit ab, input string where);
        clr        = c;
        load_valid = lv;
        load_val   = lval[3:0];
        en         = e;
        abort      = ab;
        @(posedge clk);
        model_edge(c, lv, lval, e, ab);
        #1;
        check_all(where);
    endtask

    // Counts enabled edges until tc is seen, capped so the bench cannot hang
    task automatic run_until_tc(output int cyc);
        cyc = 0;
        do begin
            apply_stimulus(1, 0, 0, 1, 0, "run");
            cyc++;
        end while (!tc && cyc < 40);
    endtask

    initial begin
        int n;
        int tcs;
        clr = 0; load_valid = 0; load_val = 0; en = 0; abort = 0;

        apply_stimulus(0, 0, 0, 0, 0, "reset0");
        apply_stimulus(0, 0, 0, 0, 0, "reset1");

        // One-shot load 3: tc after the 4th edge
        apply_stimulus(1, 1, 3, 1, 0, "load3");
        run_until_tc(n);
        check_output("latency_n3", 32'(n), 32'd4);
        apply_stimulus(1, 0, 0, 1, 0, "after3");

        // Pause three cycles at count 1, load during run dropped
        apply_stimulus(1, 0, 0, 0, 1, "exit_a");
        apply_stimulus(1, 1, 2, 1, 0, "load2");
        apply_stimulus(1, 0, 0, 1, 0, "p_run");
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 9, 0, 0, "paused");
        run_until_tc(n);
        check_output("latency_pause", 32'(n + 4), 32'd6);

        // Abort at count 1, then abort on the terminal edge
        apply_stimulus(1, 0, 0, 0, 1, "exit_b");
        apply_stimulus(1, 1, 3, 1, 0, "ab_load");
        apply_stimulus(1, 0, 0, 1, 0, "ab_c2");
        apply_stimulus(1, 0, 0, 1, 0, "ab_c1");
        apply_stimulus(1, 0, 0, 1, 1, "abort1");
        apply_stimulus(1, 1, 0, 1, 0, "ab_load0");
        apply_stimulus(1, 0, 0, 1, 1, "abort_term");

        // Edge values 0 and 15
        apply_stimulus(1, 1, 0, 1, 0, "load0");
        run_until_tc(n);
        check_output("latency_n0", 32'(n), 32'd1);
        apply_stimulus(1, 0, 0, 1, 1, "exit_c");
        apply_stimulus(1, 1, 15, 1, 0, "load15");
        run_until_tc(n);
        check_output("latency_n15", 32'(n), 32'd16);

        // clr mid-run at count 7
        apply_stimulus(1, 0, 0, 1, 1, "exit_d");
        apply_stimulus(1, 1, 10, 1, 0, "load10");
        for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 1, 0, "to7");
        apply_stimulus(0, 0, 0, 1, 0, "clr_mid");

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Periodic: load 2 gives a tc every 3 enabled edges
        apply_stimulus(1, 1, 2, 1, 0, "auto_load");
        tcs = 0;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1, 0, 0, 1, 0, "auto_run");
            if (tc) tcs++;
        end
        check_output("auto_tc_count", 32'(tcs), 32'd3);
`else
        tcs = 0;
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 99) >= 3,
                           $urandom_range(0, 99) < 30,
                           int'($urandom_range(0, 15)),
                           $urandom_range(0, 99) < 75,
                           $urandom_range(0, 99) < 5,
                           "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
